// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and sequencer that shares one data-memory port between two requesters.
// Each access runs IDLE -> ACCESS -> WAIT (LAT-1 cycles) -> CAPTURE -> RESP, and every
// output is registered.
module data_mem_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reqA,
    input  logic             weA,
    input  logic [WIDTH-1:0] addrA,
    input  logic [WIDTH-1:0] wdataA,
    output logic             ackA,
    input  logic             reqB,
    input  logic             weB,
    input  logic [WIDTH-1:0] addrB,
    input  logic [WIDTH-1:0] wdataB,
    output logic             ackB,
    output logic [WIDTH-1:0] rdata,
    output logic             sel,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StWait,
        StCapture,
        StResp
    } state_e;

    // WAIT runs LAT-1 cycles: load LAT-2 and leave when the counter is already 0.
    localparam logic [2:0] WaitLoad = (LAT > 1) ? 3'(LAT - 2) : 3'd0;

    state_e           state_q;
    logic             last_a_q;   // 1 = A won the most recent grant
    logic             we_q;
    logic [2:0]       cnt_q;
    logic             ack_a_q;
    logic             ack_b_q;
    logic [WIDTH-1:0] rdata_q;
    logic             sel_q;
    logic             mem_en_q;
    logic             mem_we_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;

    logic grant_a;

    // On a tie, A wins only when B won last.
    assign grant_a = reqA & (~reqB | ~last_a_q);

    // Transaction sequencer: state, wait counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            last_a_q <= 1'b0;
            we_q     <= 1'b0;
            cnt_q    <= 3'd0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            rdata_q  <= '0;
            sel_q    <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (reqA || reqB) begin
                        sel_q    <= grant_a;
                        last_a_q <= grant_a;
                        addr_q   <= grant_a ? addrA : addrB;
                        wdata_q  <= grant_a ? wdataA : wdataB;
                        we_q     <= grant_a ? weA : weB;
                        mem_we_q <= grant_a ? weA : weB;
                        mem_en_q <= 1'b1;
                        state_q  <= StAccess;
                    end
                end
                StAccess: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (LAT > 1) begin
                        cnt_q   <= WaitLoad;
                        state_q <= StWait;
                    end else begin
                        state_q <= StCapture;
                    end
                end
                StWait: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= StCapture;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StCapture: begin
                    if (!we_q) begin
                        rdata_q <= mem_rdata;
                    end
                    ack_a_q <= sel_q;
                    ack_b_q <= ~sel_q;
                    state_q <= StResp;
                end
                StResp: begin
                    ack_a_q <= 1'b0;
                    ack_b_q <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ackA      = ack_a_q;
    assign ackB      = ack_b_q;
    assign rdata     = rdata_q;
    assign sel       = sel_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: four instances with LAT = 1, 2, 4, 7 share one clock. Each lane
// runs a short directed prelude and then random traffic. A transaction-level model gives the
// expected value of every output on every cycle.
module tb_data_mem_arbiter;

    localparam int NCYC = 2500;

    localparam int SIG_ACKA = 0;
    localparam int SIG_ACKB = 1;
    localparam int SIG_RDATA = 2;
    localparam int SIG_SEL = 3;
    localparam int SIG_EN = 4;
    localparam int SIG_WE = 5;

    typedef struct {
        int          lane;
        int          cyc;
        string       nm;
        int          sig;
        logic [31:0] val;
    } lit_t;

    logic clk;
    int   n_vec;
    int   n_bad;
    lit_t lits[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int lat, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s LAT=%0d cycle %0d: got %h, expected %h", nm, lat, cyc, act, exp);
        end
    endtask

    function automatic void add_lit(input int lane, input int cyc, input string nm,
                                    input int sig, input logic [31:0] val);
        lit_t e;
        e.lane = lane;
        e.cyc  = cyc;
        e.nm   = nm;
        e.sig  = sig;
        e.val  = val;
        lits.push_back(e);
    endfunction

    // Hand-derived expectations. Lane 0: LAT=1, 1: LAT=2, 2: LAT=4, 3: LAT=7.
    initial begin
        n_vec = 0;
        n_bad = 0;
        for (int g = 0; g < 4; g++) begin
            add_lit(g, 0, "reset_sel", SIG_SEL, 32'h0);
            add_lit(g, 0, "reset_rdata", SIG_RDATA, 32'h0);
            add_lit(g, 0, "reset_en", SIG_EN, 32'h0);
        end
        add_lit(0, 2, "wrB_we", SIG_WE, 32'h1);
        add_lit(0, 2, "wrB_sel", SIG_SEL, 32'h0);
        add_lit(0, 3, "wrB_we_off", SIG_WE, 32'h0);
        add_lit(0, 4, "wrB_ack", SIG_ACKB, 32'h1);
        add_lit(0, 4, "wrB_rdata_hold", SIG_RDATA, 32'h0);
        add_lit(0, 8, "rdA_ack", SIG_ACKA, 32'h1);
        add_lit(0, 8, "rdA_data", SIG_RDATA, 32'h1234_5678);
        add_lit(0, 12, "rr_ackB", SIG_ACKB, 32'h1);
        add_lit(0, 16, "rr_ackA", SIG_ACKA, 32'h1);
        add_lit(0, 20, "rr_ackB2", SIG_ACKB, 32'h1);
        add_lit(1, 2, "single_en", SIG_EN, 32'h1);
        add_lit(1, 2, "single_sel", SIG_SEL, 32'h1);
        add_lit(1, 5, "single_ackA", SIG_ACKA, 32'h1);
        add_lit(1, 5, "single_rdata", SIG_RDATA, 32'hDEAD_BEEF);
        add_lit(1, 5, "single_ackB", SIG_ACKB, 32'h0);
        add_lit(1, 7, "drop_no_access", SIG_EN, 32'h0);
        add_lit(2, 5, "midrst_en", SIG_EN, 32'h0);
        add_lit(2, 5, "midrst_sel", SIG_SEL, 32'h0);
        add_lit(2, 7, "midrst_noack", SIG_ACKA, 32'h0);
        add_lit(2, 12, "postrst_ackB", SIG_ACKB, 32'h1);
        add_lit(2, 14, "tie_sel", SIG_SEL, 32'h1);
        add_lit(2, 14, "tie_en", SIG_EN, 32'h1);
        add_lit(2, 19, "tie_ackA", SIG_ACKA, 32'h1);
        add_lit(3, 9, "lat7_noack", SIG_ACKA, 32'h0);
        add_lit(3, 10, "lat7_ack1", SIG_ACKA, 32'h1);
        add_lit(3, 20, "lat7_ack2", SIG_ACKA, 32'h1);
        add_lit(3, 30, "lat7_ack3", SIG_ACKA, 32'h1);
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 7;

        logic        rst;
        logic        reqA;
        logic        weA;
        logic [31:0] addrA;
        logic [31:0] wdataA;
        logic        ackA;
        logic        reqB;
        logic        weB;
        logic [31:0] addrB;
        logic [31:0] wdataB;
        logic        ackB;
        logic [31:0] rdata;
        logic        sel;
        logic        mem_en;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] mem_rdata;

        data_mem_arbiter #(
            .WIDTH(32),
            .LAT  (L)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .reqA     (reqA),
            .weA      (weA),
            .addrA    (addrA),
            .wdataA   (wdataA),
            .ackA     (ackA),
            .reqB     (reqB),
            .weB      (weB),
            .addrB    (addrB),
            .wdataB   (wdataB),
            .ackB     (ackB),
            .rdata    (rdata),
            .sel      (sel),
            .mem_en   (mem_en),
            .mem_we   (mem_we),
            .mem_addr (mem_addr),
            .mem_wdata(mem_wdata),
            .mem_rdata(mem_rdata)
        );

        initial begin
            logic [31:0] env_mem[16];
            logic [31:0] model_mem[16];
            int          pend;
            logic [3:0]  paddr;
            logic        fire;
            int          mode;
            int          pct;
            // Transaction model: offset counts cycles since the IDLE cycle that granted.
            logic        m_busy;
            int          m_off;
            logic        m_lastA;
            logic        m_win;
            logic        m_we;
            logic [31:0] m_addr;
            logic [31:0] m_wdata;
            logic [31:0] m_rdata;
            logic [31:0] act;
            logic        e_en;

            rst = 1'b1;
            reqA = 1'b0;
            reqB = 1'b0;
            weA = 1'b0;
            weB = 1'b0;
            addrA = '0;
            addrB = '0;
            wdataA = '0;
            wdataB = '0;
            mem_rdata = '0;
            pend = 0;
            paddr = '0;
            mode = 0;
            m_busy = 1'b0;
            m_off = 0;
            m_lastA = 1'b0;
            m_win = 1'b0;
            m_we = 1'b0;
            m_addr = '0;
            m_wdata = '0;
            m_rdata = '0;
            for (int i = 0; i < 16; i++) begin
                env_mem[i] = $urandom;
                model_mem[i] = env_mem[i];
            end
            env_mem[0] = 32'hDEAD_BEEF;
            model_mem[0] = 32'hDEAD_BEEF;

            for (int cyc = 0; cyc < NCYC; cyc++) begin
                @(posedge clk);
                // Advance the model with the inputs the DUT just sampled.
                if (m_busy && m_off == 1 && m_we) model_mem[m_addr[3:0]] = m_wdata;
                if (rst) begin
                    m_busy = 1'b0;
                    m_off = 0;
                    m_lastA = 1'b0;
                    m_we = 1'b0;
                    m_addr = '0;
                    m_wdata = '0;
                    m_rdata = '0;
                    m_win = 1'b0;
                end else if (!m_busy) begin
                    if (reqA || reqB) begin
                        m_win = reqA && (!reqB || !m_lastA);
                        m_lastA = m_win;
                        m_busy = 1'b1;
                        m_off = 1;
                        m_we = m_win ? weA : weB;
                        m_addr = m_win ? addrA : addrB;
                        m_wdata = m_win ? wdataA : wdataB;
                    end
                end else begin
                    m_off++;
                    if (m_off == L + 2 && !m_we) m_rdata = model_mem[m_addr[3:0]];
                    if (m_off == L + 3) begin
                        m_busy = 1'b0;
                        m_off = 0;
                    end
                end

                @(negedge clk);
                e_en = m_busy && m_off == 1;
                chk("mem_en", L, cyc, 32'(mem_en), 32'(e_en));
                chk("mem_we", L, cyc, 32'(mem_we), 32'(e_en && m_we));
                chk("ackA", L, cyc, 32'(ackA), 32'(m_busy && m_off == L + 2 && m_win));
                chk("ackB", L, cyc, 32'(ackB), 32'(m_busy && m_off == L + 2 && !m_win));
                chk("sel", L, cyc, 32'(sel), 32'(m_win));
                chk("mem_addr", L, cyc, mem_addr, m_addr);
                chk("mem_wdata", L, cyc, mem_wdata, m_wdata);
                chk("rdata", L, cyc, rdata, m_rdata);

                foreach (lits[i]) begin
                    if (lits[i].lane == g && lits[i].cyc == cyc) begin
                        case (lits[i].sig)
                            SIG_ACKA: act = 32'(ackA);
                            SIG_ACKB: act = 32'(ackB);
                            SIG_RDATA: act = rdata;
                            SIG_SEL: act = 32'(sel);
                            SIG_EN: act = 32'(mem_en);
                            default: act = 32'(mem_we);
                        endcase
                        chk(lits[i].nm, L, cyc, act, lits[i].val);
                    end
                end

                // Memory with a LAT-cycle read pipeline; garbage outside the valid cycle.
                fire = 1'b0;
                if (pend > 0) begin
                    pend--;
                    fire = (pend == 0);
                end
                mem_rdata = fire ? env_mem[paddr] : $urandom;
                if (mem_en && mem_we) env_mem[mem_addr[3:0]] = mem_wdata;
                if (mem_en && !mem_we) begin
                    pend = L;
                    paddr = mem_addr[3:0];
                end

                // Inputs for the next edge.
                if (cyc < 40) begin
                    rst = 1'b0;
                    reqA = 1'b0;
                    reqB = 1'b0;
                    weA = 1'b0;
                    weB = 1'b0;
                    addrA = $urandom;
                    addrB = $urandom;
                    wdataA = $urandom;
                    wdataB = $urandom;
                    case (g)
                        0: begin
                            if (cyc == 1) begin
                                reqB = 1'b1;
                                weB = 1'b1;
                                addrB = 32'h20;
                                wdataB = 32'h1234_5678;
                            end
                            if (cyc == 5) begin
                                reqA = 1'b1;
                                addrA = 32'h20;
                            end
                            if (cyc >= 9 && cyc <= 24) begin
                                reqA = 1'b1;
                                reqB = 1'b1;
                            end
                        end
                        1: begin
                            if (cyc == 1 || cyc == 2) begin
                                reqA = 1'b1;
                                addrA = 32'h10;
                            end
                        end
                        2: begin
                            if (cyc == 1) begin
                                reqA = 1'b1;
                                addrA = 32'h3;
                            end
                            if (cyc == 4) rst = 1'b1;
                            if (cyc == 6) reqB = 1'b1;
                            if (cyc == 13) begin
                                reqA = 1'b1;
                                reqB = 1'b1;
                            end
                        end
                        default: begin
                            if (cyc >= 1 && cyc <= 30) reqA = 1'b1;
                        end
                    endcase
                end else begin
                    if (cyc % 200 == 40) mode = int'($urandom_range(0, 2));
                    pct = (mode == 0) ? 90 : (mode == 1) ? 15 : 50;
                    reqA = (int'($urandom_range(0, 99)) < pct);
                    reqB = (int'($urandom_range(0, 99)) < pct);
                    weA = 1'($urandom_range(0, 1));
                    weB = 1'($urandom_range(0, 1));
                    addrA = $urandom;
                    addrB = $urandom;
                    wdataA = $urandom;
                    wdataB = $urandom;
                    rst = ($urandom_range(0, 149) == 0);
                end
            end
        end
    end

    initial begin
        repeat (NCYC + 20) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
